// File: rtl/tron_mem_sequencer.sv
// Tron CPU memory sequencer: request/ack memory port, IR/load registers, retire pulse.
// Optional low-priority video read channel: define TRON_VIDEO_PORT_EN.
module tron_mem_sequencer #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                TIMEOUT_CYC = 64,
    parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef TRON_VIDEO_PORT_EN
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
`endif
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              exec_load,
    input  logic              exec_store,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] load_data,
    output logic              fetch_phase,
    output logic              step,
    output logic              bus_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
`ifdef TRON_VIDEO_PORT_EN
        S_VIDEO,
`endif
        S_RETIRE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   load_q, load_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acked;
    logic                expired;
`ifdef TRON_VIDEO_PORT_EN
    logic [DATA_W-1:0]   vdata_q, vdata_d;
    logic                vack_q, vack_d;
    logic                vused_q, vused_d;
`endif

    // Ack in the final wait cycle beats the timeout.
    assign acked   = mem_req && mem_ack;
    assign expired = mem_req && !mem_ack && (TIMEOUT_CYC != 0)
                     && (cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            instr_q <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef TRON_VIDEO_PORT_EN
            vdata_q <= '0;
            vack_q  <= 1'b0;
            vused_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            load_q  <= load_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef TRON_VIDEO_PORT_EN
            vdata_q <= vdata_d;
            vack_q  <= vack_d;
            vused_q <= vused_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        load_d  = load_q;
        err_d   = err_q;
`ifdef TRON_VIDEO_PORT_EN
        vdata_d = vdata_q;
        vack_d  = 1'b0;
        vused_d = vused_q;
`endif
        unique case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (acked) begin
                    instr_d = mem_rdata;
                    state_d = S_DECODE;
                end else if (expired) begin
                    instr_d = NOP_WORD;
                    err_d   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (exec_load && exec_store) begin
                    err_d   = 1'b1;
                    state_d = S_RETIRE;
                end else if (exec_load) begin
                    state_d = S_LOAD;
                end else if (exec_store) begin
                    state_d = S_STORE;
                end else begin
                    state_d = S_RETIRE;
                end
            end
            S_LOAD: begin
                if (acked) begin
                    load_d  = mem_rdata;
                    state_d = S_RETIRE;
                end else if (expired) begin
                    load_d  = '1;
                    err_d   = 1'b1;
                    state_d = S_RETIRE;
                end
            end
            S_STORE: begin
                if (acked) begin
                    state_d = S_RETIRE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_RETIRE;
                end
            end
`ifdef TRON_VIDEO_PORT_EN
            S_RETIRE: begin
                // Alternate slots so video can never starve fetch.
                if (vid_req && !vused_q) begin
                    vused_d = 1'b1;
                    state_d = S_VIDEO;
                end else begin
                    vused_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_VIDEO: begin
                if (acked) begin
                    vdata_d = mem_rdata;
                    vack_d  = 1'b1;
                    state_d = S_FETCH;
                end else if (expired) begin
                    vdata_d = '1;
                    vack_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
`else
            S_RETIRE: state_d = S_FETCH;
`endif
            default: state_d = S_BOOT;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_req && !mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        step        = 1'b0;
        fetch_phase = 1'b0;
        unique case (state_q)
            S_BOOT: fetch_phase = 1'b1;
            S_FETCH: begin
                fetch_phase = 1'b1;
                mem_req     = 1'b1;
                mem_addr    = pc_addr;
            end
            S_LOAD: begin
                mem_req  = 1'b1;
                mem_addr = data_addr;
            end
            S_STORE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = data_addr;
                mem_wdata = store_data;
            end
`ifdef TRON_VIDEO_PORT_EN
            S_VIDEO: begin
                mem_req  = 1'b1;
                mem_addr = vid_addr;
            end
`endif
            S_RETIRE: step = 1'b1;
            default: ;
        endcase
    end

    assign instr_out = instr_q;
    assign load_data = load_q;
    assign bus_error = err_q;
`ifdef TRON_VIDEO_PORT_EN
    assign vid_rdata = vdata_q;
    assign vid_ack   = vack_q;
`endif

endmodule

// File: tb/tb_tron_mem_sequencer.sv
// Bench for tron_mem_sequencer: directed table, async reset sequence,
// and randomized instruction stream checked against a phase-level model.
module tb_tron_mem_sequencer;

    localparam int TO = 4;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk;
    logic        reset;
    logic [15:0] pc_addr, data_addr, store_data;
    logic        exec_load, exec_store;
    logic [15:0] instr_out, load_data;
    logic        fetch_phase, step, bus_error;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    logic [15:0] instr_m, load_m;
    logic        err_m;

    tron_mem_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .pc_addr(pc_addr), .data_addr(data_addr),
        .store_data(store_data),
        .exec_load(exec_load), .exec_store(exec_store),
        .instr_out(instr_out), .load_data(load_data),
        .fetch_phase(fetch_phase), .step(step),
        .bus_error(bus_error),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ld, st;
        int          fw, dw;
        logic [15:0] pc, da, sd, ir, dr;
        logic [15:0] e_instr, e_load;
        logic        e_err;
        int          e_cyc;
    } vec_t;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] rw();
        return 16'($urandom);
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one cycle's inputs, then compare the port-level bundle.
    task automatic drive(input logic er, ew,
                         input logic [15:0] ea, ewd,
                         input logic efp, est,
                         input string nm,
                         input logic ack,
                         input logic [15:0] rd,
                         input logic el, es);
        logic [35:0] e, a;
        mem_ack = ack;
        mem_rdata = rd;
        exec_load = el;
        exec_store = es;
        #1;
        e = {er, er & ew, er ? ea : 16'h0,
             (er && ew) ? ewd : 16'h0, efp, est};
        a = {mem_req, er & mem_we, er ? mem_addr : 16'h0,
             (er && ew) ? mem_wdata : 16'h0, fetch_phase, step};
        chk(nm, 64'(a), 64'(e));
    endtask

    // One instruction, from the first FETCH cycle to the end of RETIRE.
    task automatic run_instr(input bit ld, st, input int fw, dw,
                             input logic [15:0] pc, da, sd, ir, dr,
                             output int cyc);
        int n;
        string nm;
        cyc = 0;
        pc_addr = pc;
        data_addr = da;
        store_data = sd;
        n = (fw < TO) ? fw + 1 : TO;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, pc, 16'h0, 1'b1, 1'b0, "fetch",
                  (i == fw), (i == fw) ? ir : rw(), rb(), rb());
            tick();
            cyc++;
        end
        if (fw < TO) instr_m = ir;
        else begin
            instr_m = NOP;
            err_m = 1'b1;
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "decode",
              rb(), rw(), ld, st);
        chk("instr_out", 64'(instr_out), 64'(instr_m));
        tick();
        cyc++;
        if (ld && st) err_m = 1'b1;
        else if (ld || st) begin
            nm = ld ? "load" : "store";
            n = (dw < TO) ? dw + 1 : TO;
            for (int i = 0; i < n; i++) begin
                drive(1'b1, st, da, sd, 1'b0, 1'b0, nm,
                      (i == dw), (i == dw) ? dr : rw(), rb(), rb());
                tick();
                cyc++;
            end
            if (dw < TO) begin
                if (ld) load_m = dr;
            end else begin
                err_m = 1'b1;
                if (ld) load_m = 16'hFFFF;
            end
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, "retire",
              rb(), rw(), rb(), rb());
        chk("load_data", 64'(load_data), 64'(load_m));
        chk("bus_error", 64'(bus_error), 64'(err_m));
        tick();
        cyc++;
    endtask

    initial begin
        vec_t tbl[7];
        int   cyc;
        int   k, fw, dw;

        tbl[0] = '{0, 0, 0, 0, 16'h0010, 16'h0, 16'h0, 16'h1234, 16'h0,
                   16'h1234, 16'h0000, 1'b0, 3};
        tbl[1] = '{1, 0, 0, 2, 16'h0011, 16'h00FF, 16'h0, 16'h8001, 16'hBEEF,
                   16'h8001, 16'hBEEF, 1'b0, 6};
        tbl[2] = '{0, 1, 1, 0, 16'h0012, 16'h0200, 16'hA5A5, 16'h4002, 16'h0,
                   16'h4002, 16'hBEEF, 1'b0, 5};
        tbl[3] = '{1, 0, 3, 3, 16'h0013, 16'h0300, 16'h0, 16'h8003, 16'h1357,
                   16'h8003, 16'h1357, 1'b0, 10};
        tbl[4] = '{0, 0, 9, 0, 16'h0014, 16'h0, 16'h0, 16'hFFFF, 16'h0,
                   16'h0000, 16'h1357, 1'b1, 6};
        tbl[5] = '{1, 1, 0, 0, 16'h0015, 16'h0400, 16'h0, 16'hC005, 16'h0,
                   16'hC005, 16'h1357, 1'b1, 3};
        tbl[6] = '{1, 0, 0, 7, 16'h0016, 16'h0500, 16'h0, 16'h8006, 16'h0,
                   16'h8006, 16'hFFFF, 1'b1, 7};

        reset = 1'b1;
        pc_addr = 16'h0;
        data_addr = 16'h0;
        store_data = 16'h0;
        exec_load = 1'b0;
        exec_store = 1'b0;
        mem_rdata = 16'h0;
        mem_ack = 1'b0;

        @(negedge clk);
        #1;
        chk("reset_vals",
            64'({mem_req, mem_we, step, fetch_phase, bus_error,
                 mem_addr, mem_wdata, instr_out, load_data}),
            64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0}));
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "boot",
              1'b1, rw(), 1'b0, 1'b0);
        tick();
        instr_m = 16'h0;
        load_m = 16'h0;
        err_m = 1'b0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].ld, tbl[i].st, tbl[i].fw, tbl[i].dw,
                      tbl[i].pc, tbl[i].da, tbl[i].sd, tbl[i].ir,
                      tbl[i].dr, cyc);
            chk("tbl_cycles", 64'(cyc), 64'(tbl[i].e_cyc));
            chk("tbl_instr", 64'(instr_out), 64'(tbl[i].e_instr));
            chk("tbl_load", 64'(load_data), 64'(tbl[i].e_load));
            chk("tbl_err", 64'(bus_error), 64'(tbl[i].e_err));
        end

        // Reset while a load is waiting on the bus.
        pc_addr = 16'h0300;
        data_addr = 16'h0444;
        drive(1'b1, 1'b0, 16'h0300, 16'h0, 1'b1, 1'b0, "rl_fetch",
              1'b1, 16'h8123, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "rl_decode",
              1'b0, rw(), 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 16'h0444, 16'h0, 1'b0, 1'b0, "rl_load",
              1'b0, rw(), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_async",
            64'({mem_req, mem_we, step, fetch_phase, bus_error,
                 mem_addr, mem_wdata, instr_out}),
            64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48'h0}));
        chk("rst_async_ld", 64'(load_data), 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "rl_boot",
              1'b0, rw(), 1'b0, 1'b0);
        tick();
        instr_m = 16'h0;
        load_m = 16'h0;
        err_m = 1'b0;
        run_instr(1'b0, 1'b0, 0, 0, 16'h0310, 16'h0, 16'h0,
                  16'h2222, 16'h0, cyc);
        chk("rl_cycles", 64'(cyc), 64'd3);

        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 9);
            fw = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6)
                                               : $urandom_range(0, 3);
            dw = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6)
                                               : $urandom_range(0, 3);
            run_instr(k inside {[3:5], 9}, k inside {[6:8], 9}, fw, dw,
                      rw(), rw(), rw(), rw(), rw(), cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
